// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read-side and stream-output signal bundle
//
// Parameters:
//   DATA_WIDTH  width of fifo_rdata and m_data; must match the reader instance
// Signals:
//   fifo_empty  FIFO registered empty flag           (FIFO -> reader)
//   fifo_rdata  FIFO data_out, valid after a read    (FIFO -> reader)
//   fifo_rd_en  FIFO r_en                            (reader -> FIFO)
//   m_valid     stream word available                (reader -> sink)
//   m_ready     sink accepts the word                (sink -> reader)
//   m_data      stream word                          (reader -> sink)
// Modports: master = reader side, slave = FIFO/sink side.

interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - async_fifo read-side consumer feeding a valid/ready stream
//
// Parameters:
//   DATA_WIDTH  FIFO / stream word width
//   CNT_W       width of the delivered-word counter
// Ports:
//   clk        read-domain clock (FIFO r_clk)
//   rst_n      asynchronous active-low reset (FIFO r_rst_n)
//   enable     1 = issue new FIFO reads; 0 = stop reading, let buffered words drain
//   cnt_clr    synchronous clear of words_out (wins over a same-cycle pop)
//   words_out  count of accepted stream words, wraps modulo 2^CNT_W
//   bus        FIFO read side and stream output (master modport)

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     words_out,
  fifo_stream_reader_if.master bus
);

  logic [1:0]            occ_q, occ_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  pop;
  logic                  rd_en;
  logic [2:0]            committed;

  // Credit: words buffered plus the one in flight, less the one leaving now.
  // A read may only issue if its word is guaranteed a slot when it arrives.
  // Going through pop keeps a combinational m_ready -> fifo_rd_en path so a
  // full buffer with a pop in progress can still read every cycle.
  always_comb begin
    pop       = (occ_q != 2'd0) & bus.m_ready;
    committed = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    rd_en     = rst_n & enable & ~bus.fifo_empty & (committed < 3'd2);
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_data     = entry0_q;
  assign words_out      = cnt_q;

  always_comb begin
    occ_d     = occ_q;
    rd_pend_d = rd_en;
    entry0_d  = entry0_q;
    entry1_d  = entry1_q;
    cnt_d     = cnt_q;

    if (rd_pend_q) begin
      case (occ_q)
        2'd0: begin
          entry0_d = bus.fifo_rdata;
          occ_d    = 2'd1;
        end
        2'd1: begin
          if (pop) begin
            entry0_d = bus.fifo_rdata;
          end else begin
            entry1_d = bus.fifo_rdata;
            occ_d    = 2'd2;
          end
        end
        default: begin
          // Full with no pop is excluded by the credit check above.
          if (pop) begin
            entry0_d = entry1_q;
            entry1_d = bus.fifo_rdata;
          end
        end
      endcase
    end else if (pop) begin
      entry0_d = entry1_q;
      occ_d    = occ_q - 2'd1;
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (pop) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= 2'd0;
      rd_pend_q <= 1'b0;
      entry0_q  <= '0;
      entry1_q  <= '0;
      cnt_q     <= '0;
    end else begin
      occ_q     <= occ_d;
      rd_pend_q <= rd_pend_d;
      entry0_q  <= entry0_d;
      entry1_q  <= entry1_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
